dmem_responder: RTL and testbench

- Memory-side responder for the core's load/store port. Accepts one request at a time over a valid/ready handshake.
- Performs byte, halfword or word accesses against an internal word-addressed array. Returns load data sign- or zero-extended per funct3, after a fixed, parameterised latency.
- Replaces the combinational data memory once the datapath moves to a multi-cycle or stalling memory interface.

---
 rtl/dmem_responder.sv | 215 +++++++++++++++++++++
 tb/tb_dmem_responder.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: memory-side responder for the core load/store port.
//
// Accepts one request at a time (valid/ready), performs a byte/halfword/word
// access against an internal word-addressed array and returns the extended
// load data (or an error flag) after a fixed LATENCY. Load data is registered
// on the edge that enters the response state; stores commit on that same edge.
//
// Ports:
//   i_clk           system clock, rising edge
//   i_rst_n         asynchronous active-low reset
//   i_req_valid     request present
//   o_req_ready     responder can accept a request (idle and out of reset)
//   i_req_write     1 = store, 0 = load
//   i_req_addr      byte address
//   i_req_funct3    RV32I load/store funct3
//   i_req_wdata     store data, right-aligned
//   o_rsp_valid     response present
//   i_rsp_ready     consumer accepts response
//   o_rsp_rdata     extended load result; 0 for stores and errors
//   o_rsp_err       request rejected
//
// Build option: define DMEM_ALIGN_CHECK_EN to flag misaligned halfword/word
// accesses as errors. Without it, halfwords use the addr[1] lane and words
// ignore addr[1:0].

module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_write,
  input  logic [31:0] i_req_addr,
  input  logic [2:0]  i_req_funct3,
  input  logic [31:0] i_req_wdata,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err
);

  localparam int unsigned IdxW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_t;

  state_t      r_state, w_state_d;
  logic [3:0]  r_cnt, w_cnt_d;
  logic        r_write;
  logic [31:0] r_addr;
  logic [2:0]  r_funct3;
  logic [31:0] r_wdata;
  logic        r_rsp_valid;
  logic [31:0] r_rdata;
  logic        r_err;

  logic [31:0] r_mem [DEPTH_WORDS];

  logic        w_accept;
  logic        w_enter_resp;

  // Access operands: with LATENCY=1 the access happens on the acceptance edge,
  // so the live request is used; otherwise the captured copy.
  logic        w_acc_write;
  logic [31:0] w_acc_addr;
  logic [2:0]  w_acc_funct3;
  logic [31:0] w_acc_wdata;

  logic [IdxW-1:0] w_idx;
  logic            w_in_range;
  logic            w_f3_ok;
  logic            w_misalign;
  logic            w_err;
  logic [31:0]     w_word;
  logic [31:0]     w_shift;
  logic [15:0]     w_half;
  logic [31:0]     w_ld_data;
  logic [3:0]      w_be;
  logic [31:0]     w_st_data;

  // Reset gating keeps ready low while reset is held, even though state is idle.
  assign o_req_ready = (r_state == StIdle) && i_rst_n;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_rdata = r_rdata;
  assign o_rsp_err   = r_err;

  always_comb begin
    w_state_d    = r_state;
    w_cnt_d      = r_cnt;
    w_accept     = 1'b0;
    w_enter_resp = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_req_valid && o_req_ready) begin
          w_accept = 1'b1;
          if (LATENCY == 1) begin
            w_state_d    = StResp;
            w_enter_resp = 1'b1;
          end else begin
            w_state_d = StWait;
            w_cnt_d   = 4'(LATENCY - 2);
          end
        end
      end
      StWait: begin
        if (r_cnt == 4'd0) begin
          w_state_d    = StResp;
          w_enter_resp = 1'b1;
        end else begin
          w_cnt_d = r_cnt - 4'd1;
        end
      end
      StResp: begin
        if (i_rsp_ready) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_acc_write  = (r_state == StIdle) ? i_req_write  : r_write;
    w_acc_addr   = (r_state == StIdle) ? i_req_addr   : r_addr;
    w_acc_funct3 = (r_state == StIdle) ? i_req_funct3 : r_funct3;
    w_acc_wdata  = (r_state == StIdle) ? i_req_wdata  : r_wdata;
  end

  always_comb begin
    w_idx      = w_acc_addr[IdxW+1:2];
    w_in_range = ({2'b00, w_acc_addr[31:2]} < 32'(DEPTH_WORDS));
    w_word     = w_in_range ? r_mem[w_idx] : 32'd0;

    if (w_acc_write) w_f3_ok = (w_acc_funct3 inside {3'b000, 3'b001, 3'b010});
    else             w_f3_ok = (w_acc_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});

`ifdef DMEM_ALIGN_CHECK_EN
    w_misalign = ((w_acc_funct3[1:0] == 2'b01) && w_acc_addr[0]) ||
                 ((w_acc_funct3[1:0] == 2'b10) && (w_acc_addr[1:0] != 2'b00));
`else
    w_misalign = 1'b0;
`endif

    w_err = !w_f3_ok || !w_in_range || w_misalign;

    w_shift = w_word >> {w_acc_addr[1:0], 3'b000};
    w_half  = w_acc_addr[1] ? w_word[31:16] : w_word[15:0];

    w_ld_data = 32'd0;
    if (!w_err && !w_acc_write) begin
      case (w_acc_funct3)
        3'b000:  w_ld_data = {{24{w_shift[7]}}, w_shift[7:0]};
        3'b001:  w_ld_data = {{16{w_half[15]}}, w_half};
        3'b010:  w_ld_data = w_word;
        3'b100:  w_ld_data = {24'd0, w_shift[7:0]};
        3'b101:  w_ld_data = {16'd0, w_half};
        default: w_ld_data = 32'd0;
      endcase
    end

    w_be      = 4'b0000;
    w_st_data = w_acc_wdata;
    case (w_acc_funct3[1:0])
      2'b00: begin
        w_be      = 4'b0001 << w_acc_addr[1:0];
        w_st_data = {4{w_acc_wdata[7:0]}};
      end
      2'b01: begin
        w_be      = w_acc_addr[1] ? 4'b1100 : 4'b0011;
        w_st_data = {2{w_acc_wdata[15:0]}};
      end
      2'b10:   w_be = 4'b1111;
      default: w_be = 4'b0000;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= StIdle;
      r_cnt       <= 4'd0;
      r_write     <= 1'b0;
      r_addr      <= 32'd0;
      r_funct3    <= 3'd0;
      r_wdata     <= 32'd0;
      r_rsp_valid <= 1'b0;
      r_rdata     <= 32'd0;
      r_err       <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      if (w_accept) begin
        r_write  <= i_req_write;
        r_addr   <= i_req_addr;
        r_funct3 <= i_req_funct3;
        r_wdata  <= i_req_wdata;
      end
      if (w_enter_resp) begin
        r_rsp_valid <= 1'b1;
        r_rdata     <= w_ld_data;
        r_err       <= w_err;
      end else if ((r_state == StResp) && i_rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  // Array is not reset; stores commit on the edge entering the response state.
  always_ff @(posedge i_clk) begin
    if (w_enter_resp && w_acc_write && !w_err) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_st_data[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  localparam int unsigned LAT   = 2;
  localparam int unsigned DEPTH = 1024;

`ifdef DMEM_ALIGN_CHECK_EN
  localparam logic [31:0] W10 = 32'hDEAD80EF;
`else
  localparam logic [31:0] W10 = 32'hCAFEF00D;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [2:0]  req_funct3;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  always #5 clk = ~clk;

  dmem_responder #(
    .DEPTH_WORDS(DEPTH),
    .LATENCY    (LAT)
  ) u_dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_write (req_write),
    .i_req_addr  (req_addr),
    .i_req_funct3(req_funct3),
    .i_req_wdata (req_wdata),
    .o_rsp_valid (rsp_valid),
    .i_rsp_ready (rsp_ready),
    .o_rsp_rdata (rsp_rdata),
    .o_rsp_err   (rsp_err)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  f3;
    logic [31:0] wd;
    logic [31:0] er;
    logic        ee;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input logic wr, input logic [31:0] addr, input logic [2:0] f3,
                              input logic [31:0] wd, input logic [31:0] er, input logic ee);
    vec_t v;
    v.wr = wr; v.addr = addr; v.f3 = f3; v.wd = wd; v.er = er; v.ee = ee;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Issue one request with rsp_ready=1 and score the response.
  task automatic run_req(input vec_t v, input string name);
    int   n;
    int   lat;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({name, " ready"}, 32'(req_ready), 32'd1);
    rsp_ready  = 1'b1;
    req_valid  = 1'b1;
    req_write  = v.wr;
    req_addr   = v.addr;
    req_funct3 = v.f3;
    req_wdata  = v.wd;
    sb.push_back('{rdata: v.er, err: v.ee});
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_write  = 1'($urandom);
    req_addr   = $urandom;
    req_funct3 = 3'($urandom);
    req_wdata  = $urandom;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 20);
    check({name, " latency"}, 32'(lat), 32'(LAT));
    if (rsp_valid && sb.size() > 0) begin
      e = sb.pop_front();
      check({name, " rdata"}, rsp_rdata, e.rdata);
      check({name, " err"}, 32'(rsp_err), 32'(e.err));
    end else begin
      checks++;
      errors++;
      $display("FAIL %s response: got none, required rsp_valid", name);
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = 32'd0;
    req_funct3 = 3'd0;
    req_wdata  = 32'd0;
    rsp_ready  = 1'b1;

    vecs.push_back(mk(1, 32'h10,   3'b010, 32'hDEADBEEF, 32'h0,        0));
    vecs.push_back(mk(0, 32'h10,   3'b010, 32'h0,        32'hDEADBEEF, 0));
    vecs.push_back(mk(1, 32'h11,   3'b000, 32'h80,       32'h0,        0));
    vecs.push_back(mk(0, 32'h11,   3'b000, 32'h0,        32'hFFFFFF80, 0));
    vecs.push_back(mk(0, 32'h11,   3'b100, 32'h0,        32'h00000080, 0));
    vecs.push_back(mk(0, 32'h10,   3'b001, 32'h0,        32'hFFFF80EF, 0));
    vecs.push_back(mk(0, 32'h10,   3'b010, 32'h0,        32'hDEAD80EF, 0));
    vecs.push_back(mk(1, 32'h1000, 3'b010, 32'h11111111, 32'h0,        1));
    vecs.push_back(mk(0, 32'h1000, 3'b010, 32'h0,        32'h0,        1));
    vecs.push_back(mk(0, 32'h10,   3'b011, 32'h0,        32'h0,        1));
    vecs.push_back(mk(1, 32'h10,   3'b100, 32'h55555555, 32'h0,        1));
    vecs.push_back(mk(0, 32'h10,   3'b010, 32'h0,        32'hDEAD80EF, 0));
    vecs.push_back(mk(0, 32'h12,   3'b101, 32'h0,        32'h0000DEAD, 0));
    vecs.push_back(mk(0, 32'h12,   3'b001, 32'h0,        32'hFFFFDEAD, 0));
    vecs.push_back(mk(0, 32'h13,   3'b000, 32'h0,        32'hFFFFFFDE, 0));
    vecs.push_back(mk(1, 32'h14,   3'b010, 32'h0,        32'h0,        0));
    vecs.push_back(mk(1, 32'h16,   3'b001, 32'hABCD7FFF, 32'h0,        0));
    vecs.push_back(mk(0, 32'h14,   3'b010, 32'h0,        32'h7FFF0000, 0));
`ifdef DMEM_ALIGN_CHECK_EN
    vecs.push_back(mk(0, 32'h12,   3'b010, 32'h0,        32'h0,        1));
    vecs.push_back(mk(0, 32'h11,   3'b001, 32'h0,        32'h0,        1));
    vecs.push_back(mk(1, 32'h12,   3'b010, 32'hCAFEF00D, 32'h0,        1));
`else
    vecs.push_back(mk(0, 32'h12,   3'b010, 32'h0,        32'hDEAD80EF, 0));
    vecs.push_back(mk(0, 32'h11,   3'b001, 32'h0,        32'hFFFF80EF, 0));
    vecs.push_back(mk(1, 32'h12,   3'b010, 32'hCAFEF00D, 32'h0,        0));
`endif
    vecs.push_back(mk(0, 32'h10,   3'b010, 32'h0,        W10,          0));

    // Reset state
    repeat (2) @(negedge clk);
    check("rst req_ready", 32'(req_ready), 32'd0);
    check("rst rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst rsp_rdata", rsp_rdata, 32'd0);
    check("rst rsp_err", 32'(rsp_err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post-rst req_ready", 32'(req_ready), 32'd1);

    foreach (vecs[i]) run_req(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: hold rsp_ready low for 5 cycles in the response state.
    @(negedge clk);
    rsp_ready  = 1'b0;
    req_valid  = 1'b1;
    req_write  = 1'b0;
    req_addr   = 32'h10;
    req_funct3 = 3'b010;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 20);
    check("bp latency", 32'(n), 32'(LAT));
    check("bp rdata", rsp_rdata, W10);
    for (int i = 0; i < 5; i++) begin
      req_valid  = 1'b1;
      req_write  = 1'b1;
      req_addr   = 32'h10;
      req_funct3 = 3'b010;
      req_wdata  = 32'h0BADF00D;
      @(negedge clk);
      check($sformatf("bp hold%0d valid", i), 32'(rsp_valid), 32'd1);
      check($sformatf("bp hold%0d rdata", i), rsp_rdata, W10);
      check($sformatf("bp hold%0d err", i), 32'(rsp_err), 32'd0);
      check($sformatf("bp hold%0d req_ready", i), 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp release valid", 32'(rsp_valid), 32'd0);
    check("bp release req_ready", 32'(req_ready), 32'd1);
    run_req(mk(0, 32'h10, 3'b010, 32'h0, W10, 0), "bp ignored store");

    // Reset during the wait of a store: the store must never commit.
    run_req(mk(1, 32'h20, 3'b010, 32'hA5A5A5A5, 32'h0, 0), "pre-rst sw");
    @(negedge clk);
    req_valid  = 1'b1;
    req_write  = 1'b1;
    req_addr   = 32'h20;
    req_funct3 = 3'b010;
    req_wdata  = 32'h12345678;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst_n     = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("mid-rst%0d rsp_valid", i), 32'(rsp_valid), 32'd0);
      check($sformatf("mid-rst%0d req_ready", i), 32'(req_ready), 32'd0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("post-rst%0d rsp_valid", i), 32'(rsp_valid), 32'd0);
    end
    check("post-rst idle ready", 32'(req_ready), 32'd1);
    run_req(mk(0, 32'h20, 3'b010, 32'h0, 32'hA5A5A5A5, 0), "abandoned sw");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
